// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit up/down digit counter for a seven-segment display.
// Define HEX_DIGIT_BCD_EN for a decimal digit (0..9, loads above 9 clamp to 9).
module hex_digit_counter #(
  parameter int DIV = 50000000,
  parameter int CW  = 28
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Load,
  input  logic [3:0] D,
  input  logic       Up,
  input  logic [1:0] Speed,
  output logic [3:0] Q,
  output logic       Tick,
  output logic       Carry
);

`ifdef HEX_DIGIT_BCD_EN
  localparam logic [3:0] QMAX = 4'd9;
`else
  localparam logic [3:0] QMAX = 4'hF;
`endif

  localparam logic [CW-1:0] DIVW = CW'(DIV);
  localparam logic [CW-1:0] R1   = DIVW - CW'(1);
  localparam logic [CW-1:0] R2   = (DIVW << 1) - CW'(1);
  localparam logic [CW-1:0] R3   = (DIVW << 2) - CW'(1);

  logic [CW-1:0] dcnt;
  logic [CW-1:0] reload;
  logic [4:0]    stp;

  // Returns {wrapped, next digit}.
  function automatic logic [4:0] step_digit(input logic [3:0] q, input logic up);
    if (up)
      return (q == QMAX) ? {1'b1, 4'd0} : {1'b0, q + 4'd1};
    else
      return (q == 4'd0) ? {1'b1, QMAX} : {1'b0, q - 4'd1};
  endfunction

  function automatic logic [3:0] clamp_load(input logic [3:0] d);
`ifdef HEX_DIGIT_BCD_EN
    return (d > QMAX) ? QMAX : d;
`else
    return d;
`endif
  endfunction

  always_comb begin
    reload = '0;
    case (Speed)
      2'b00:   reload = '0;
      2'b01:   reload = R1;
      2'b10:   reload = R2;
      default: reload = R3;
    endcase
  end

  assign stp = step_digit(Q, Up);

  // Load beats a pending tick; a lowered Speed clamps the divider so the
  // next tick is never later than one new period.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Q     <= 4'd0;
      dcnt  <= '0;
      Tick  <= 1'b0;
      Carry <= 1'b0;
    end else if (Load) begin
      Q     <= clamp_load(D);
      dcnt  <= reload;
      Tick  <= 1'b0;
      Carry <= 1'b0;
    end else if (!Enable) begin
      Tick  <= 1'b0;
      Carry <= 1'b0;
    end else if (dcnt == '0) begin
      dcnt  <= reload;
      Q     <= stp[3:0];
      Tick  <= 1'b1;
      Carry <= stp[4];
    end else begin
      if (dcnt > reload)
        dcnt <= reload;
      else
        dcnt <= dcnt - CW'(1);
      Tick  <= 1'b0;
      Carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench for hex_digit_counter with DIV=4; expectations are hand-derived.
module tb_hex_digit_counter;

`ifdef HEX_DIGIT_BCD_EN
  localparam int M   = 10;
  localparam int LC  = 9;
  localparam int LN  = 0;
  localparam bit LNC = 1'b1;
`else
  localparam int M   = 16;
  localparam int LC  = 12;
  localparam int LN  = 13;
  localparam bit LNC = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Enable;
  logic       Load;
  logic [3:0] D;
  logic       Up;
  logic [1:0] Speed;
  logic [3:0] Q;
  logic       Tick;
  logic       Carry;

  int vectors = 0;
  int misc    = 0;

  hex_digit_counter #(.DIV(4), .CW(8)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Enable(Enable),
    .Load  (Load),
    .D     (D),
    .Up    (Up),
    .Speed (Speed),
    .Q     (Q),
    .Tick  (Tick),
    .Carry (Carry)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int q, input bit t, input bit c);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {Q, Tick, Carry};
    exp = {4'(q), t, c};
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: got Q=%h Tick=%b Carry=%b, expected Q=%h Tick=%b Carry=%b",
             tag, Q, Tick, Carry, exp[5:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    Resetn = 1'b0; Enable = 1'b0; Load = 1'b0; D = 4'd0; Up = 1'b1; Speed = 2'b00;
    repeat (2) @(negedge Clock);
    check("reset", 0, 1'b0, 1'b0);

    // Speed 00: step every cycle, wrap raises Carry once
    Resetn = 1'b1; Enable = 1'b1;
    for (int i = 1; i <= M + 1; i++) begin
      @(negedge Clock);
      check("run00", i % M, 1'b1, i == M);
    end

    Speed = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clock);
      check("div01", 1 + (c + 3) / 4, (c % 4) == 1, 1'b0);
    end

    Speed = 2'b10;
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clock);
      check("div10", (c == 9) ? 5 : 4, (c == 1) || (c == 9), 1'b0);
    end

    Load = 1'b1; D = 4'd0; Speed = 2'b11;
    @(negedge Clock);
    check("load_s11", 0, 1'b0, 1'b0);
    Load = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge Clock);
      check("div11", c / 16, (c % 16) == 0, 1'b0);
    end

    // Divider now at 12 with Speed=11; lowering to 01 clamps it to 3
    repeat (3) begin
      @(negedge Clock);
      check("pre_lower", 2, 1'b0, 1'b0);
    end
    Speed = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clock);
      check("lowered", (c == 5) ? 3 : 2, c == 5, 1'b0);
    end

    Load = 1'b1; D = 4'd7;
    @(negedge Clock);
    check("load7", 7, 1'b0, 1'b0);
    Load = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      check("wait_dc0", 7, 1'b0, 1'b0);
    end
    Load = 1'b1; D = 4'hC;
    @(negedge Clock);
    check("load_prio", LC, 1'b0, 1'b0);
    Load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      check("after_load", (c == 4) ? LN : LC, c == 4, (c == 4) && LNC);
    end

    Load = 1'b1; D = 4'd1; Up = 1'b0; Speed = 2'b00;
    @(negedge Clock);
    check("load1", 1, 1'b0, 1'b0);
    Load = 1'b0;
    @(negedge Clock);
    check("down", 0, 1'b1, 1'b0);
    @(negedge Clock);
    check("down_wrap", M - 1, 1'b1, 1'b1);
    Enable = 1'b0;
    repeat (10) begin
      @(negedge Clock);
      check("freeze", M - 1, 1'b0, 1'b0);
    end
    Enable = 1'b1;
    @(negedge Clock);
    check("reenable", M - 2, 1'b1, 1'b0);
    Up = 1'b1;
    @(negedge Clock);
    check("dir_up", M - 1, 1'b1, 1'b0);

    Load = 1'b1; D = 4'd8;
    @(negedge Clock);
    check("load8", 8, 1'b0, 1'b0);
    Load = 1'b0;
    @(negedge Clock);
    check("pre_reset", 9, 1'b1, 1'b0);
    #2 Resetn = 1'b0;
    #1 check("async_rst", 0, 1'b0, 1'b0);
    @(negedge Clock);
    check("hold_rst", 0, 1'b0, 1'b0);
    Resetn = 1'b1;
    @(negedge Clock);
    check("first_tick", 1, 1'b1, 1'b0);

`ifdef HEX_DIGIT_BCD_EN
    Load = 1'b1; D = 4'hE;
    @(negedge Clock);
    check("bcd_clamp", 9, 1'b0, 1'b0);
    Load = 1'b0;
    @(negedge Clock);
    check("bcd_wrap", 0, 1'b1, 1'b1);
`else
    Load = 1'b1; D = 4'hE;
    @(negedge Clock);
    check("load_e", 14, 1'b0, 1'b0);
    Load = 1'b0;
    @(negedge Clock);
    check("step_f", 15, 1'b1, 1'b0);
    @(negedge Clock);
    check("wrap_up", 0, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
